// File: rtl/bytecode_fetch_pkg.sv
// Shared Java bytecode definitions: opcode constants, fetch FSM encodings and
// the operand-length table reused by the fetch stage and the ARM generator.
package bytecode_fetch_pkg;

    localparam logic [7:0] OP_ICONST_0 = 8'h03;
    localparam logic [7:0] OP_ICONST_5 = 8'h08;
    localparam logic [7:0] OP_BIPUSH   = 8'h10;
    localparam logic [7:0] OP_SIPUSH   = 8'h11;
    localparam logic [7:0] OP_ILOAD    = 8'h15;
    localparam logic [7:0] OP_ILOAD_0  = 8'h1A;
    localparam logic [7:0] OP_ILOAD_3  = 8'h1D;
    localparam logic [7:0] OP_ISTORE   = 8'h36;
    localparam logic [7:0] OP_ISTORE_0 = 8'h3B;
    localparam logic [7:0] OP_ISTORE_3 = 8'h3E;
    localparam logic [7:0] OP_IADD     = 8'h60;
    localparam logic [7:0] OP_ISUB     = 8'h64;
    localparam logic [7:0] OP_IINC     = 8'h84;
    localparam logic [7:0] OP_GOTO     = 8'hA7;
    localparam logic [7:0] OP_RETURN   = 8'hB1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ_OP   = 3'd1;
    localparam logic [2:0] S_CAP_OP   = 3'd2;
    localparam logic [2:0] S_REQ_OPND = 3'd3;
    localparam logic [2:0] S_CAP_OPND = 3'd4;
    localparam logic [2:0] S_OUTPUT   = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    // Returns {illegal, len[1:0]}; unknown opcodes are treated as length 0.
    function automatic logic [2:0] java_operand_len(input logic [7:0] op);
        logic [2:0] r;
        r = 3'b100;
        if ((op >= OP_ICONST_0 && op <= OP_ICONST_5) ||
            (op >= OP_ILOAD_0  && op <= OP_ILOAD_3)  ||
            (op >= OP_ISTORE_0 && op <= OP_ISTORE_3) ||
            op == OP_IADD || op == OP_ISUB || op == OP_RETURN)
            r = 3'b000;
        else if (op == OP_BIPUSH || op == OP_ILOAD || op == OP_ISTORE)
            r = 3'b001;
        else if (op == OP_SIPUSH || op == OP_IINC || op == OP_GOTO)
            r = 3'b010;
        return r;
    endfunction

endpackage

// File: rtl/bytecode_fetch_length_decoder.sv
// Combinational opcode decoder: operand byte count and illegal flag.
module bytecode_length_decoder
    import bytecode_fetch_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] num_operands,
    output logic       illegal
);

    always_comb begin
        {illegal, num_operands} = java_operand_len(opcode);
    end

endmodule

// File: rtl/bytecode_fetch.sv
// Bytecode fetch stage: walks the ROM and emits one Java instruction per handshake.
// Optional simulation trace of accepted bundles with JAA_FETCH_TRACE_EN defined.
module bytecode_fetch
  import bytecode_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            opcode,
  output logic [7:0]            operand1,
  output logic [7:0]            operand2,
  output logic [1:0]            num_operands,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  illegal,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  second_opnd;
  logic [1:0]            dec_len;
  logic                  dec_illegal;

  bytecode_length_decoder u_len_dec (
    .opcode       (rom_data),
    .num_operands (dec_len),
    .illegal      (dec_illegal)
  );

  assign instr_valid = (state == S_OUTPUT);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= START_PC;
      rom_addr     <= START_PC;
      instr_pc     <= START_PC;
      opcode       <= '0;
      operand1     <= '0;
      operand2     <= '0;
      num_operands <= '0;
      illegal      <= 1'b0;
      second_opnd  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc    <= START_PC;
            state <= S_REQ_OP;
          end
        end
        S_REQ_OP: begin
          rom_addr <= pc;
          state    <= S_CAP_OP;
        end
        S_CAP_OP: begin
          opcode       <= rom_data;
          instr_pc     <= pc;
          num_operands <= dec_len;
          illegal      <= dec_illegal;
          operand1     <= '0;
          operand2     <= '0;
          second_opnd  <= 1'b0;
          pc           <= pc + PC_ONE;
          state        <= (dec_len == 2'd0) ? S_OUTPUT : S_REQ_OPND;
        end
        S_REQ_OPND: begin
          rom_addr <= pc;
          state    <= S_CAP_OPND;
        end
        S_CAP_OPND: begin
          if (second_opnd)
            operand2 <= rom_data;
          else
            operand1 <= rom_data;
          second_opnd <= 1'b1;
          pc          <= pc + PC_ONE;
          state       <= (second_opnd || num_operands == 2'd1) ? S_OUTPUT : S_REQ_OPND;
        end
        S_OUTPUT: begin
          if (instr_ready)
            state <= (opcode == OP_RETURN) ? S_DONE : S_REQ_OP;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef JAA_FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && instr_valid && instr_ready)
      $display("%h %h %h %h%s", instr_pc, opcode, operand1, operand2,
               illegal ? " ILLEGAL" : "");
  end
`endif

endmodule

// File: tb/tb_bytecode_fetch.sv
// Scoreboard bench for bytecode_fetch: directed ROM programs, one DUT at
// START_ADDR=0 and one at START_ADDR=63 for the address-wrap case.
module tb_bytecode_fetch;

    typedef struct {
        logic [5:0] pc;
        logic [7:0] opc;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] n;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_m = 1'b0, start_w = 1'b0;
    logic ready = 1'b1;
    logic sel = 1'b0;

    logic [7:0] rom_m [64];
    logic [7:0] rom_w [64];

    logic [5:0] addr_m, addr_w, ipc_m, ipc_w;
    logic [7:0] data_m, data_w;
    logic       valid_m, valid_w, ill_m, ill_w, done_m, done_w;
    logic [7:0] opc_m, opc_w, op1_m, op1_w, op2_m, op2_w;
    logic [1:0] n_m, n_w;

    assign data_m = rom_m[addr_m];
    assign data_w = rom_w[addr_w];

    bytecode_fetch #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .START_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start_m), .rom_addr(addr_m), .rom_data(data_m),
        .instr_valid(valid_m), .instr_ready(ready), .opcode(opc_m), .operand1(op1_m),
        .operand2(op2_m), .num_operands(n_m), .instr_pc(ipc_m), .illegal(ill_m), .done(done_m)
    );

    bytecode_fetch #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .START_ADDR(63)) dut_wrap (
        .clk(clk), .reset(reset), .start(start_w), .rom_addr(addr_w), .rom_data(data_w),
        .instr_valid(valid_w), .instr_ready(ready), .opcode(opc_w), .operand1(op1_w),
        .operand2(op2_w), .num_operands(n_w), .instr_pc(ipc_w), .illegal(ill_w), .done(done_w)
    );

    logic       mon_valid, mon_ill, mon_done;
    logic [5:0] mon_pc;
    logic [7:0] mon_opc, mon_op1, mon_op2;
    logic [1:0] mon_n;
    assign mon_valid = sel ? valid_w : valid_m;
    assign mon_ill   = sel ? ill_w   : ill_m;
    assign mon_done  = sel ? done_w  : done_m;
    assign mon_pc    = sel ? ipc_w   : ipc_m;
    assign mon_opc   = sel ? opc_w   : opc_m;
    assign mon_op1   = sel ? op1_w   : op1_m;
    assign mon_op2   = sel ? op2_w   : op2_m;
    assign mon_n     = sel ? n_w     : n_m;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;
    int mark = 0;
    exp_t sb[$];
    logic prev_v = 1'b0;
    logic exp_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic exp_t mk(input logic [5:0] pc, input logic [7:0] opc, input logic [7:0] op1,
                                input logic [7:0] op2, input logic [1:0] n, input logic ill);
        exp_t e;
        e.pc = pc; e.opc = opc; e.op1 = op1; e.op2 = op2; e.n = n; e.ill = ill;
        return e;
    endfunction

    // Monitor: latency from start/previous handshake, bundle contents, done after return.
    always @(negedge clk) begin
        exp_t e;
        if (exp_done) begin
            chk("done_after_return", 64'(mon_done), 64'(1));
            exp_done = 1'b0;
        end
        if (mon_valid && !prev_v && sb.size() > 0)
            chk("valid_latency", 64'(cyc - mark), 64'(3 + 2 * int'(sb[0].n)));
        if (mon_valid && ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_bundle: got pc=%h opcode=%h, expected no bundle", mon_pc, mon_opc);
            end else begin
                e = sb.pop_front();
                chk("bundle", {mon_pc, mon_opc, mon_op1, mon_op2, mon_n, mon_ill},
                              {e.pc, e.opc, e.op1, e.op2, e.n, e.ill});
                if (e.opc == 8'hB1) exp_done = 1'b1;
            end
            mark = cyc;
        end
        prev_v = mon_valid;
    end

    task automatic pulse_start(input logic wrap);
        @(posedge clk); #1;
        if (wrap) start_w = 1'b1; else start_m = 1'b1;
        mark = cyc;
        @(posedge clk); #1;
        start_m = 1'b0;
        start_w = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n;
        rom_m = '{default: 8'h00};
        rom_w = '{default: 8'h00};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_values", {valid_m, addr_m, opc_m, op1_m, op2_m, n_m, ipc_m, ill_m, done_m}, 64'(0));

        // zero-operand program
        rom_m[0] = 8'h03; rom_m[1] = 8'h3C; rom_m[2] = 8'hB1;
        sb.push_back(mk(6'd0, 8'h03, 8'h00, 8'h00, 2'd0, 1'b0));
        sb.push_back(mk(6'd1, 8'h3C, 8'h00, 8'h00, 2'd0, 1'b0));
        sb.push_back(mk(6'd2, 8'hB1, 8'h00, 8'h00, 2'd0, 1'b0));
        pulse_start(1'b0);
        wait_drain();

        // bipush / sipush / return, restarted from DONE
        rom_m = '{default: 8'h00};
        rom_m[0] = 8'h10; rom_m[1] = 8'h7F; rom_m[2] = 8'h11;
        rom_m[3] = 8'h01; rom_m[4] = 8'h02; rom_m[5] = 8'hB1;
        sb.push_back(mk(6'd0, 8'h10, 8'h7F, 8'h00, 2'd1, 1'b0));
        sb.push_back(mk(6'd2, 8'h11, 8'h01, 8'h02, 2'd2, 1'b0));
        sb.push_back(mk(6'd5, 8'hB1, 8'h00, 8'h00, 2'd0, 1'b0));
        pulse_start(1'b0);
        wait_drain();

        // backpressure: ready low for five valid cycles of a sipush
        rom_m = '{default: 8'h00};
        rom_m[0] = 8'h11; rom_m[1] = 8'hAB; rom_m[2] = 8'hCD; rom_m[3] = 8'hB1;
        sb.push_back(mk(6'd0, 8'h11, 8'hAB, 8'hCD, 2'd2, 1'b0));
        sb.push_back(mk(6'd3, 8'hB1, 8'h00, 8'h00, 2'd0, 1'b0));
        ready = 1'b0;
        pulse_start(1'b0);
        n = 0;
        @(negedge clk);
        while (!valid_m && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_hold", {valid_m, addr_m, opc_m, op1_m, op2_m, n_m, ipc_m},
                              {1'b1, 6'd2, 8'h11, 8'hAB, 8'hCD, 2'd2, 6'd0});
        end
        @(posedge clk); #1;
        ready = 1'b1;
        wait_drain();

        // illegal opcode followed by return
        rom_m = '{default: 8'h00};
        rom_m[0] = 8'hFF; rom_m[1] = 8'hB1;
        sb.push_back(mk(6'd0, 8'hFF, 8'h00, 8'h00, 2'd0, 1'b1));
        sb.push_back(mk(6'd1, 8'hB1, 8'h00, 8'h00, 2'd0, 1'b0));
        pulse_start(1'b0);
        wait_drain();

        // reset during the first operand capture of an iinc
        rom_m = '{default: 8'h00};
        rom_m[0] = 8'h84; rom_m[1] = 8'h05; rom_m[2] = 8'h01; rom_m[3] = 8'hB1;
        pulse_start(1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_abort", {valid_m, addr_m, opc_m, op1_m, op2_m, n_m, ipc_m, ill_m, done_m}, 64'(0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("idle_after_abort", {valid_m, done_m, addr_m}, 64'(0));
        sb.push_back(mk(6'd0, 8'h84, 8'h05, 8'h01, 2'd2, 1'b0));
        sb.push_back(mk(6'd3, 8'hB1, 8'h00, 8'h00, 2'd0, 1'b0));
        pulse_start(1'b0);
        wait_drain();

        // operand fetch wraps from address 63 to 0
        sel = 1'b1;
        @(posedge clk);
        rom_w[63] = 8'h10; rom_w[0] = 8'h55; rom_w[1] = 8'hB1;
        sb.push_back(mk(6'd63, 8'h10, 8'h55, 8'h00, 2'd1, 1'b0));
        sb.push_back(mk(6'd1, 8'hB1, 8'h00, 8'h00, 2'd0, 1'b0));
        pulse_start(1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
